// File: rtl/pdu_uart_tx_pkg.sv
// rtl/pdu_uart_tx_pkg.sv - shared register map, status layout and FSM encoding for pdu_uart_tx
package pdu_uart_tx_pkg;

    localparam logic [1:0] ADDR_TXDATA = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 8;

    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // A divisor below two cannot hold a bit for a full baud period.
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/pdu_uart_tx_fifo.sv
// rtl/pdu_uart_tx_fifo.sv - byte FIFO feeding the UART transmit shifter
module pdu_uart_tx_fifo #(
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [FIFO_DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0]   DEPTH_CNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE   = FIFO_DEPTH_LOG2'(1);
    localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE   = (FIFO_DEPTH_LOG2 + 1)'(1);

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count_q;
    logic                       do_push;
    logic                       do_pop;

    // Both qualifiers look at the pre-edge occupancy, so a push into an
    // empty FIFO is never popped in the same cycle and a full FIFO drops.
    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pdu_uart_tx.sv
// rtl/pdu_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
module pdu_uart_tx
    import pdu_uart_tx_pkg::*;
#(
    parameter int          CLK_FREQ        = 100000000,
    parameter int          BAUD            = 115200,
    parameter int          FIFO_DEPTH_LOG2 = 4,
    parameter logic [15:0] DIV_RESET       = 16'(CLK_FREQ / BAUD)
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] interface_addr,
    output logic [31:0] interface_rdata,
    input  logic [31:0] interface_wdata,
    input  logic        interface_we,
    output logic        uart_txd
);

    logic [1:0]  reg_sel;
    logic        wr_txdata;
    logic        wr_status;
    logic        wr_div;
    logic [15:0] div_reg;
    logic        overflow;

    logic        fifo_push;
    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;
    logic [7:0]  count8;
    logic [31:0] status_word;
    logic        unused_bits;

    tx_state_t   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] div_q, div_d;
    logic        txd_q, txd_d;
    logic        baud_done;

    assign reg_sel     = interface_addr[3:2];
    assign wr_txdata   = interface_we && (reg_sel == ADDR_TXDATA);
    assign wr_status   = interface_we && (reg_sel == ADDR_STATUS);
    assign wr_div      = interface_we && (reg_sel == ADDR_DIV);
    assign fifo_push   = wr_txdata && !fifo_full;
    assign unused_bits = ^{interface_addr[31:4], interface_addr[1:0], interface_wdata[31:16]};

    pdu_uart_tx_fifo #(
        .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (interface_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            overflow <= 1'b0;
            div_reg  <= DIV_RESET;
        end else begin
            if (wr_status) begin
                overflow <= 1'b0;
            end else if (wr_txdata && fifo_full) begin
                overflow <= 1'b1;
            end
            if (wr_div) begin
                div_reg <= clamp_div(interface_wdata[15:0]);
            end
        end
    end

    assign count8 = 8'(fifo_count);

    always_comb begin
        status_word                              = '0;
        status_word[STAT_FULL]                   = fifo_full;
        status_word[STAT_EMPTY]                  = fifo_empty;
        status_word[STAT_BUSY]                   = (state_q != ST_IDLE);
        status_word[STAT_OVERFLOW]               = overflow;
        status_word[STAT_COUNT_LSB +: 8]         = count8;
    end

    always_comb begin
        interface_rdata = '0;
        case (reg_sel)
            ADDR_STATUS: interface_rdata = status_word;
            ADDR_DIV:    interface_rdata = {16'h0000, div_reg};
            default:     interface_rdata = '0;
        endcase
    end

    assign baud_done = (baud_q == div_q - 16'd1);

    // div_q is sampled only when a byte is loaded, so DIV writes never
    // disturb the frame already on the wire.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        div_d    = div_q;
        txd_d    = txd_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    div_d    = div_reg;
                    txd_d    = 1'b0;
                    baud_d   = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        div_d    = div_reg;
                        txd_d    = 1'b0;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            div_q   <= DIV_RESET;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            txd_q   <= txd_d;
        end
    end

    assign uart_txd = txd_q;

endmodule

// File: tb/tb_pdu_uart_tx.sv
// tb/tb_pdu_uart_tx.sv - directed self-checking bench for pdu_uart_tx
module tb_pdu_uart_tx;

    localparam logic [31:0] A_TXDATA = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_DIV    = 32'h8;
    localparam logic [31:0] A_RSVD   = 32'hC;
    localparam logic [31:0] DIV_RESET_EXP = 32'd868;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [31:0] interface_addr;
    logic [31:0] interface_rdata;
    logic [31:0] interface_wdata;
    logic        interface_we;
    logic        uart_txd;

    int n_cmp  = 0;
    int n_fail = 0;

    pdu_uart_tx dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .interface_addr  (interface_addr),
        .interface_rdata (interface_rdata),
        .interface_wdata (interface_wdata),
        .interface_we    (interface_we),
        .uart_txd        (uart_txd)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        interface_addr  = a;
        interface_wdata = d;
        interface_we    = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        interface_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        interface_addr = a;
        interface_we   = 1'b0;
        #1;
        d = interface_rdata;
    endtask

    // Entered on the negedge 'pre' cycles into the start bit; samples mid-bit.
    task automatic decode_frame(input int div, input int pre, output logic [7:0] data,
                                output logic start_b, output logic stop_b);
        repeat (div / 2 - pre) @(negedge sys_clk);
        start_b = uart_txd;
        for (int i = 0; i < 8; i++) begin
            repeat (div) @(negedge sys_clk);
            data[i] = uart_txd;
        end
        repeat (div) @(negedge sys_clk);
        stop_b = uart_txd;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        n_cmp++;
        if (uart_txd !== 1'b1) begin
            n_fail++; $display("FAIL reset_txd: got %b expected 1", uart_txd);
        end
        bus_read(A_STATUS, rd);
        n_cmp++;
        if (rd !== 32'h2) begin
            n_fail++; $display("FAIL reset_status: got %h expected 00000002", rd);
        end
        bus_read(A_DIV, rd);
        n_cmp++;
        if (rd !== DIV_RESET_EXP) begin
            n_fail++; $display("FAIL reset_div: got %h expected %h", rd, DIV_RESET_EXP);
        end
        bus_read(A_TXDATA, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL read_txdata: got %h expected 00000000", rd);
        end
    endtask

    task automatic test_single_frame();
        logic [31:0] rd;
        logic [7:0]  d;
        logic        sb, pb;
        @(negedge sys_clk);
        bus_write(A_DIV, 32'd4);
        bus_write(A_RSVD, 32'hFFFF_FFFF);
        bus_read(A_RSVD, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL read_rsvd: got %h expected 00000000", rd);
        end
        @(negedge sys_clk);
        bus_write(A_TXDATA, 32'h55);
        n_cmp++;
        if (uart_txd !== 1'b1) begin
            n_fail++; $display("FAIL single_early: got %b expected 1", uart_txd);
        end
        @(negedge sys_clk);
        n_cmp++;
        if (uart_txd !== 1'b0) begin
            n_fail++; $display("FAIL single_start_edge: got %b expected 0", uart_txd);
        end
        decode_frame(4, 0, d, sb, pb);
        n_cmp++;
        if ({sb, d, pb} !== {1'b0, 8'h55, 1'b1}) begin
            n_fail++; $display("FAIL single_frame: got start=%b data=%h stop=%b expected 0 55 1", sb, d, pb);
        end
        @(negedge sys_clk);
        bus_read(A_STATUS, rd);
        n_cmp++;
        if (rd !== 32'h6) begin
            n_fail++; $display("FAIL single_busy_last: got %h expected 00000006", rd);
        end
        @(negedge sys_clk);
        bus_read(A_STATUS, rd);
        n_cmp++;
        if (rd !== 32'h2) begin
            n_fail++; $display("FAIL single_idle: got %h expected 00000002", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [7:0]  d1, d2;
        logic        s1, p1, s2, p2;
        @(negedge sys_clk);
        bus_write(A_TXDATA, 32'hA5);
        bus_write(A_TXDATA, 32'h0F);
        decode_frame(4, 0, d1, s1, p1);
        @(negedge sys_clk);
        n_cmp++;
        if (uart_txd !== 1'b1) begin
            n_fail++; $display("FAIL b2b_stop_tail: got %b expected 1", uart_txd);
        end
        @(negedge sys_clk);
        n_cmp++;
        if (uart_txd !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second_start: got %b expected 0", uart_txd);
        end
        decode_frame(4, 0, d2, s2, p2);
        n_cmp++;
        if ({s1, d1, p1, s2, d2, p2} !== {1'b0, 8'hA5, 1'b1, 1'b0, 8'h0F, 1'b1}) begin
            n_fail++; $display("FAIL b2b_bytes: got %h %h (s/p %b%b %b%b) expected a5 0f", d1, d2, s1, p1, s2, p2);
        end
        repeat (2) @(negedge sys_clk);
        bus_read(A_STATUS, rd);
        n_cmp++;
        if (rd !== 32'h2) begin
            n_fail++; $display("FAIL b2b_idle: got %h expected 00000002", rd);
        end
    endtask

    task automatic test_div_change();
        logic [31:0] rd;
        logic [7:0]  d1, d2;
        logic        s1, p1, s2, p2;
        @(negedge sys_clk);
        bus_write(A_DIV, 32'd4);
        bus_write(A_TXDATA, 32'h00);
        bus_write(A_TXDATA, 32'hC3);
        bus_write(A_DIV, 32'd8);
        bus_read(A_DIV, rd);
        n_cmp++;
        if (rd !== 32'd8) begin
            n_fail++; $display("FAIL divchg_readback: got %h expected 00000008", rd);
        end
        decode_frame(4, 1, d1, s1, p1);
        n_cmp++;
        if ({s1, d1, p1} !== {1'b0, 8'h00, 1'b1}) begin
            n_fail++; $display("FAIL divchg_first: got start=%b data=%h stop=%b expected 0 00 1", s1, d1, p1);
        end
        repeat (2) @(negedge sys_clk);
        n_cmp++;
        if (uart_txd !== 1'b0) begin
            n_fail++; $display("FAIL divchg_second_start: got %b expected 0", uart_txd);
        end
        decode_frame(8, 0, d2, s2, p2);
        n_cmp++;
        if ({s2, d2, p2} !== {1'b0, 8'hC3, 1'b1}) begin
            n_fail++; $display("FAIL divchg_second: got start=%b data=%h stop=%b expected 0 c3 1", s2, d2, p2);
        end
        repeat (4) @(negedge sys_clk);
        bus_read(A_STATUS, rd);
        n_cmp++;
        if (rd !== 32'h2) begin
            n_fail++; $display("FAIL divchg_idle: got %h expected 00000002", rd);
        end
        bus_write(A_DIV, 32'd1);
        bus_read(A_DIV, rd);
        n_cmp++;
        if (rd !== 32'd2) begin
            n_fail++; $display("FAIL div_clamp: got %h expected 00000002", rd);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic [7:0]  d;
        logic        sb, pb;
        int          prev_div;
        int          stray;
        @(negedge sys_clk);
        bus_write(A_DIV, 32'd100);
        for (int i = 0; i < 17; i++) begin
            bus_write(A_TXDATA, 32'h10 + i);
        end
        bus_read(A_STATUS, rd);
        n_cmp++;
        if (rd !== 32'h0000_1005) begin
            n_fail++; $display("FAIL ovf_full: got %h expected 00001005", rd);
        end
        bus_write(A_TXDATA, 32'hEE);
        bus_read(A_STATUS, rd);
        n_cmp++;
        if (rd !== 32'h0000_100D) begin
            n_fail++; $display("FAIL ovf_set: got %h expected 0000100d", rd);
        end
        bus_write(A_STATUS, 32'h0);
        bus_read(A_STATUS, rd);
        n_cmp++;
        if (rd !== 32'h0000_1005) begin
            n_fail++; $display("FAIL ovf_clear: got %h expected 00001005", rd);
        end
        bus_write(A_DIV, 32'd2);
        decode_frame(100, 18, d, sb, pb);
        n_cmp++;
        if ({sb, d, pb} !== {1'b0, 8'h10, 1'b1}) begin
            n_fail++; $display("FAIL ovf_frame0: got start=%b data=%h stop=%b expected 0 10 1", sb, d, pb);
        end
        prev_div = 100;
        for (int k = 1; k < 17; k++) begin
            repeat (prev_div - prev_div / 2) @(negedge sys_clk);
            decode_frame(2, 0, d, sb, pb);
            n_cmp++;
            if ({sb, d, pb} !== {1'b0, 8'(8'h10 + k), 1'b1}) begin
                n_fail++; $display("FAIL ovf_frame%0d: got start=%b data=%h stop=%b expected 0 %h 1", k, sb, d, pb, 8'(8'h10 + k));
            end
            prev_div = 2;
        end
        stray = 0;
        repeat (60) begin
            @(negedge sys_clk);
            if (uart_txd !== 1'b1) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin
            n_fail++; $display("FAIL ovf_dropped_byte: got %0d low cycles expected 0", stray);
        end
        bus_read(A_STATUS, rd);
        n_cmp++;
        if (rd !== 32'h2) begin
            n_fail++; $display("FAIL ovf_idle: got %h expected 00000002", rd);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        int          stray;
        @(negedge sys_clk);
        bus_write(A_DIV, 32'd4);
        bus_write(A_TXDATA, 32'h00);
        bus_write(A_TXDATA, 32'h00);
        repeat (10) @(negedge sys_clk);
        n_cmp++;
        if (uart_txd !== 1'b0) begin
            n_fail++; $display("FAIL rst_pre_data: got %b expected 0", uart_txd);
        end
        #1 sys_rst = 1'b1;
        #1;
        n_cmp++;
        if (uart_txd !== 1'b1) begin
            n_fail++; $display("FAIL rst_async_txd: got %b expected 1", uart_txd);
        end
        bus_read(A_STATUS, rd);
        n_cmp++;
        if (rd !== 32'h2) begin
            n_fail++; $display("FAIL rst_status: got %h expected 00000002", rd);
        end
        bus_read(A_DIV, rd);
        n_cmp++;
        if (rd !== DIV_RESET_EXP) begin
            n_fail++; $display("FAIL rst_div: got %h expected %h", rd, DIV_RESET_EXP);
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        stray = 0;
        repeat (60) begin
            @(negedge sys_clk);
            if (uart_txd !== 1'b1) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin
            n_fail++; $display("FAIL rst_no_frame: got %0d low cycles expected 0", stray);
        end
        bus_read(A_STATUS, rd);
        n_cmp++;
        if (rd !== 32'h2) begin
            n_fail++; $display("FAIL rst_after_status: got %h expected 00000002", rd);
        end
    endtask

    initial begin
        sys_rst         = 1'b1;
        interface_addr  = '0;
        interface_wdata = '0;
        interface_we    = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_div_change();
        test_overflow();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pdu_uart_tx.md
Name: pdu_uart_tx

Overview:
Memory-mapped UART transmitter on the PDU data bus. It accepts bytes through bus writes, buffers them in a small FIFO, and serialises them on uart_txd as 8N1 frames. It responds to the same addr/rdata/wdata/we interface the PDU bus gives its peripherals, and is the transmit end of the serial link whose receiver sits on the host side.

Parameters:
CLK_FREQ, 100000000, sys_clk frequency in Hz
BAUD, 115200, default baud rate
FIFO_DEPTH_LOG2, 4, TX FIFO holds 2**FIFO_DEPTH_LOG2 bytes
DIV_RESET, CLK_FREQ/BAUD, reset value of the divisor register (16-bit, must be >= 2)

Ports:
sys_clk  in  1  clock
sys_rst  in  1  reset; asynchronous, active-high
interface_addr  in  32  byte address; only [3:2] decoded
interface_rdata  out  32  combinational read data
interface_wdata  in  32  write data
interface_we  in  1  write strobe, one byte/word per cycle while high
uart_txd  out  1  serial output, idle high

Behaviour:
- Register map, selected by addr[3:2]:
  - 0 = TXDATA (W): push wdata[7:0]; reads return 0.
  - 1 = STATUS (R): bit0 full, bit1 empty, bit2 busy (FSM != IDLE), bit3 overflow (sticky), bits[15:8] FIFO count, remaining bits 0. Any write clears overflow.
  - 2 = DIV (RW): bits[15:0] cycles per bit. Writes of 0 or 1 are clamped to 2.
  - 3: reads 0, writes ignored.
- Reset (async): FIFO empty, count 0, overflow 0, DIV = DIV_RESET, FSM IDLE, uart_txd = 1, interface_rdata reflects the reset STATUS/DIV values.
- Push rule: on a TXDATA write, the push happens only if the FIFO is not full before the edge. If full, the byte is dropped and overflow is set, even when a pop occurs in the same cycle.
- Pop rule: the FSM pops only if the FIFO is non-empty before the edge. A push into an empty FIFO cannot be popped in the same cycle.
- FSM states are IDLE, START, DATA, STOP. A bit counter (0..7) and a baud counter (0..div_q-1) are registered; uart_txd is registered.
  - IDLE: if the FIFO is non-empty, pop the byte into a shift register, latch DIV into div_q, set txd = 0, and go to START.
  - START: after div_q cycles, txd = shift[0] and go to DATA.
  - DATA: every div_q cycles, shift right and output the next bit, LSB first. After the 8th bit has been held div_q cycles, txd = 1 and go to STOP.
  - STOP: hold for div_q cycles. Then, if the FIFO is non-empty, pop, set txd = 0 and go to START with no idle gap; otherwise go to IDLE.
- Latency: a push at edge N into an empty FIFO while IDLE makes txd fall at edge N+1. A frame is exactly 10*div_q cycles.
- A DIV write during a frame takes effect only at the next frame start.
- Reset asserted mid-frame aborts the frame immediately: txd = 1 and the FIFO is flushed.
- The FIFO read pointer, write pointer and count wrap modulo depth. Full means count == depth.

Decomposition:
- Package pdu_uart_tx_pkg:
  - address offsets (TXDATA=0, STATUS=1, DIV=2)
  - STATUS bit positions
  - FSM state encoding
  - minimum DIV constant (2)
- Sub-module pdu_uart_tx_fifo: synchronous 8-bit FIFO, parameter FIFO_DEPTH_LOG2. Ports: push, pop, din, dout (head, valid while non-empty), full, empty, count. Async reset, same rules as above.
- The top level contains the register decode, the FSM and the baud/bit counters.

Test Plan:
- Reset then read STATUS -> 0x00000002 (empty). Read DIV -> DIV_RESET. uart_txd = 1.
- Write DIV=4, then TXDATA=0x55 -> txd low 1 cycle after the write edge. Sampling every 4 cycles gives 0,1,0,1,0,1,0,1,0,1 (start, LSB-first 0x55, stop). busy=1 for 40 cycles, then STATUS = 0x00000002.
- DIV=4, back-to-back writes 0xA5 then 0x0F -> second start bit begins exactly 40 cycles after the first. No idle cycle between frames. Decoded bytes are 0xA5, 0x0F.
- DIV=100, write 17 bytes with depth 16 -> first byte popped into the shifter, 16 in FIFO. STATUS full=1, count=16, no overflow. An 18th write gives overflow=1 and that byte never appears on txd. Any STATUS write then clears overflow.
- DIV=4, write byte 0x00, rewrite DIV=8 mid-frame -> current frame keeps 4-cycle bits. The next byte sent uses 8-cycle bits.
- DIV=4, assert sys_rst mid-DATA (asynchronously, between edges) -> txd = 1 immediately, STATUS = 0x00000002, DIV = DIV_RESET. No further frame after release.
